// File: rtl/tcdm_pkg.sv
// tcdm_pkg: shared TCDM widths and read/write encoding
package tcdm_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W = 4;
   localparam logic WEN_READ = 1'b1;
   localparam logic WEN_WRITE = 1'b0;
endpackage

// File: rtl/tcdm_bank_responder_if.sv
// tcdm_bank_responder_if: bundled multi-port TCDM request/response bus
interface tcdm_bank_responder_if
   import tcdm_pkg::*;
#(
   parameter int N_PORTS = 4
);
   logic [N_PORTS-1:0] req_i;
   logic [N_PORTS-1:0] gnt_o;
   logic [N_PORTS-1:0][ADDR_W-1:0] add_i;
   logic [N_PORTS-1:0] wen_i;
   logic [N_PORTS-1:0][BE_W-1:0] be_i;
   logic [N_PORTS-1:0][DATA_W-1:0] wdata_i;
   logic [N_PORTS-1:0][DATA_W-1:0] r_rdata_o;
   logic [N_PORTS-1:0] r_valid_o;
   modport master (
      output req_i, add_i, wen_i, be_i, wdata_i,
      input gnt_o, r_rdata_o, r_valid_o
   );
   modport slave (
      input req_i, add_i, wen_i, be_i, wdata_i,
      output gnt_o, r_rdata_o, r_valid_o
   );
endinterface

// File: rtl/tcdm_rr_arb.sv
// tcdm_rr_arb: round-robin arbiter, first requester at or after ptr wins
module tcdm_rr_arb #(
   parameter int N_PORTS = 4,
   parameter int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input logic clk_i,
   input logic rst_i,
   input logic [N_PORTS-1:0] req_i,
   output logic [N_PORTS-1:0] gnt_o,
   output logic [IW-1:0] idx_o
);
   logic [IW-1:0] ptr_q;
   logic any;
   // scan from the farthest offset down so the closest requester to ptr is kept
   always_comb begin
      any = 1'b0;
      idx_o = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (req_i[(int'(ptr_q) + i) % N_PORTS]) begin
            any = 1'b1;
            idx_o = IW'((int'(ptr_q) + i) % N_PORTS);
         end
      end
      gnt_o = any ? N_PORTS'(1) << idx_o : '0;
   end
   // pointer moves past the winner on a grant, holds otherwise
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else if (any) ptr_q <= (int'(idx_o) == N_PORTS - 1) ? '0 : idx_o + 1'b1;
   end
endmodule

// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: single-bank TCDM memory serving N ports with one-cycle responses
module tcdm_bank_responder
   import tcdm_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int MEM_WORDS = 1024
) (
   input logic clk_i,
   input logic rst_i,
   tcdm_bank_responder_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   typedef struct packed {
      logic valid;
      logic [IW-1:0] idx;
      logic rd;
      logic [DATA_W-1:0] data;
   } rsp_t;
   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic [N_PORTS-1:0] req_m, gnt;
   logic [IW-1:0] idx;
   logic [AW-1:0] widx;
   logic any, wr, unused_addr;
   rsp_t rsp_q;
   assign req_m = rst_i ? '0 : bus.req_i;
   tcdm_rr_arb #(.N_PORTS(N_PORTS), .IW(IW)) u_arb (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_i(req_m),
      .gnt_o(gnt),
      .idx_o(idx)
   );
   assign bus.gnt_o = gnt;
   assign any = |gnt;
   assign widx = bus.add_i[idx][AW+1:2];
   assign wr = any && bus.wen_i[idx] == WEN_WRITE;
   assign unused_addr = ^{bus.add_i[idx][ADDR_W-1:AW+2], bus.add_i[idx][1:0]};
   // byte-masked write of the granted port; memory is deliberately not reset
   always_ff @(posedge clk_i) begin
      if (wr)
         for (int b = 0; b < BE_W; b++)
            if (bus.be_i[idx][b]) mem[widx][8*b +: 8] <= bus.wdata_i[idx][8*b +: 8];
   end
   // response stage: reads capture the word as it was at the grant edge
   always_ff @(posedge clk_i) begin
      if (rst_i) rsp_q <= '0;
      else begin
         rsp_q.valid <= any;
         rsp_q.idx <= idx;
         rsp_q.rd <= any && bus.wen_i[idx] == WEN_READ;
         rsp_q.data <= mem[widx];
      end
   end
   // route the response to its port; everything else and writes read as zero
   always_comb begin
      bus.r_valid_o = '0;
      bus.r_rdata_o = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         bus.r_valid_o[i] = !rst_i && rsp_q.valid && int'(rsp_q.idx) == i;
         bus.r_rdata_o[i] = (bus.r_valid_o[i] && rsp_q.rd) ? rsp_q.data : '0;
      end
   end
endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of TCDM master ports served.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: 32-bit words in the bank, power of two.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_i, input, [N_PORTS]: per-port request.
REQ-006 SHALL have port gnt_o, output, [N_PORTS]: per-port grant, combinational from req_i and the arbiter state.
REQ-007 SHALL have port add_i, input, [N_PORTS][32]: byte address.
REQ-008 SHALL have port wen_i, input, [N_PORTS]: 1 = read, 0 = write.
REQ-009 SHALL have port be_i, input, [N_PORTS][4]: byte enables.
REQ-010 SHALL have port wdata_i, input, [N_PORTS][32]: write data.
REQ-011 SHALL have port r_rdata_o, output, [N_PORTS][32]: response data.
REQ-012 SHALL have port r_valid_o, output, [N_PORTS]: response valid.

Function
REQ-013 SHALL grant at most one port per cycle; gnt_o is one-hot or zero.
REQ-014 SHALL assert gnt_o[i] only when req_i[i]=1.
REQ-015 SHALL use round-robin arbitration with a priority pointer ptr: the first requesting port at or after ptr, modulo N_PORTS, wins.
REQ-016 SHALL set ptr to (granted index + 1) mod N_PORTS on every granted cycle, and SHALL hold ptr when no port is granted.
REQ-017 SHALL form the word index as add_i[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so the address wraps modulo the bank size.
REQ-018 SHALL, on a granted write, update only the bytes whose be_i bit is 1, at the clock edge of the grant.
REQ-019 SHALL, on a granted read, return the word's contents as at the grant edge on r_rdata_o of the granted port in the following cycle.
REQ-020 SHALL assert r_valid_o[i] for exactly one cycle, the cycle after every grant to port i, for reads and for writes alike.
REQ-021 SHALL drive r_rdata_o to 0 on a write response and on every port with r_valid_o=0.
REQ-022 SHALL sustain one grant per cycle back-to-back, so a port holding req high with no contention is granted every cycle.
REQ-023 SHALL handle a read in cycle n+1 to a word written in cycle n by returning the new data.
REQ-024 SHALL ignore be_i on reads; a write with be_i=0 SHALL be granted and acknowledged but SHALL leave memory unchanged.
REQ-025 SHALL keep a requester that is denied a grant ungranted, with no response and no side effect; the master keeps req high and the block holds no state for it.

Reset
REQ-026 SHALL, while rst_i=1, force gnt_o=0, r_valid_o=0 and r_rdata_o=0, and SHALL set ptr=0.
REQ-027 SHALL leave memory contents unreset, so they are undefined after power-up and retained across reset.
REQ-028 SHALL discard a response pending when rst_i rises mid-operation: no r_valid_o in the cycle after reset is released.

Structure
REQ-029 SHALL take the widths (ADDR_W=32, DATA_W=32, BE_W=4) and the read/write encoding constants from shared package tcdm_pkg.
REQ-030 SHALL implement arbitration in sub-module tcdm_rr_arb, parameterised by N_PORTS, with outputs one-hot grant and grant index.
REQ-031 SHALL register the response in one pipeline stage holding valid, port index, is-read flag and data.

Verification
REQ-032 SHALL cover single-port write then read: port0 writes 0xDEADBEEF at 0x40 with be=0xF, then reads 0x40 -> r_valid_o[0] one cycle after each grant, and the read returns 0xDEADBEEF.
REQ-033 SHALL cover byte enables: memory at 0x40 holds 0xDEADBEEF; a write of 0x11223344 with be=0x5 -> a later read returns 0xDE22BE44.
REQ-034 SHALL cover round-robin fairness: all 4 ports hold req for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, with one r_valid per port per grant.
REQ-035 SHALL cover wrap-around: with MEM_WORDS=1024, a write of 0xA5A5A5A5 at 0x1000 -> a read at 0x0 returns 0xA5A5A5A5.
REQ-036 SHALL cover write-then-read forwarding: port1 writes 0x12345678 to 0x8 in cycle n and port2 reads 0x8 in cycle n+1 -> port2 receives 0x12345678.
REQ-037 SHALL cover reset mid-operation: rst_i asserted in the cycle a read is granted -> no r_valid_o follows, ptr=0, and port0 wins first after reset when all ports request.
